// File: rtl/banked_ram_ctrl.sv
// Banked single-clock RAM behind a valid/ready request port with a one-cycle
// registered response. After every reset, all banks are cleared before any request is accepted.
module banked_ram_ctrl #(
    parameter int DATA_W    = 8,
    parameter int BANK_AW   = 9,
    parameter int NUM_BANKS = 3,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    // state | meaning
    // INIT  | writing 0 to word init_cnt of every bank; requests refused
    // RUN   | accepting one request per cycle
    typedef enum logic {INIT, RUN} state_t;

    // First out-of-range address; one extra bit covers a fully populated map.
    localparam int unsigned     LIMIT_I = NUM_BANKS * (2 ** BANK_AW);
    localparam logic [ADDR_W:0] LIMIT   = LIMIT_I[ADDR_W:0];
    localparam logic [BANK_AW-1:0] LAST = '1;

    state_t               state, state_nxt;
    logic [BANK_AW-1:0]   init_cnt;
    logic [ADDR_W-1:0]    bank_idx;
    logic [BANK_AW-1:0]   offset;
    logic                 in_range;
    logic                 accept;
    logic                 init_wr;
    logic [BANK_AW-1:0]   wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [NUM_BANKS-1:0] bank_we;
    logic [NUM_BANKS-1:0] rd_sel_q;
    logic [DATA_W-1:0]    bank_rd [NUM_BANKS];

    assign req_ready = (state == RUN);
    assign init_done = (state == RUN);

    assign bank_idx = req_addr >> BANK_AW;
    assign offset   = req_addr[BANK_AW-1:0];
    assign in_range = ({1'b0, req_addr} < LIMIT);

    // Reset takes priority over a request or an init write on the same edge.
    assign accept  = req_valid & req_ready & ~rst;
    assign init_wr = (state == INIT) & ~rst;
    assign wr_addr = init_wr ? init_cnt : offset;
    assign wr_data = init_wr ? '0 : req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (init_cnt == LAST) state_nxt = RUN;
            RUN:  state_nxt = RUN;
        endcase
    end

    // Each bank has one write port and one registered read port.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [2**BANK_AW];
        logic [DATA_W-1:0] rd_q;

        assign bank_we[b] = init_wr |
                            (accept & req_we & in_range & (bank_idx == ADDR_W'(b)));

        always_ff @(posedge clk) begin
            if (bank_we[b]) mem[wr_addr] <= wr_data;
            rd_q <= mem[offset];
        end

        assign bank_rd[b] = rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_sel_q  <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & ~in_range;
            for (int b = 0; b < NUM_BANKS; b++)
                rd_sel_q[b] <= accept & ~req_we & in_range & (bank_idx == ADDR_W'(b));
        end
    end

    // Read data is driven only by the selected bank, so writes, errors and idle cycles output zero.
    always_comb begin
        rsp_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (rd_sel_q[b]) rsp_rdata = bank_rd[b];
    end
endmodule
